// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle, LSB first,
// with signed operands handled as magnitudes plus a sign flag applied at the end.
//
// state | meaning
// IDLE  | waiting for start, c holds the last result
// RUN   | one multiplier bit processed per cycle, busy=1
// DONE  | c just loaded, done=1 for this single cycle
module seq_multiplier #(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] c
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              capture;
    logic              last_bit;

    logic [2*SIZE-1:0] mcand;
    logic [2*SIZE-1:0] acc;
    logic [2*SIZE-1:0] acc_sum;
    logic [SIZE-1:0]   mplier;
    logic [SIZE-1:0]   a_mag;
    logic [SIZE-1:0]   b_mag;
    logic [CW-1:0]     cnt;
    logic              neg;

    assign last_bit = (cnt == CW'(1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The magnitude of the most-negative value wraps to itself, which read as
    // unsigned is exactly the right magnitude.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (signed_mode && a[SIZE-1]) begin
            a_mag = ~a + SIZE'(1);
        end
        if (signed_mode && b[SIZE-1]) begin
            b_mag = ~b + SIZE'(1);
        end
    end

    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            c      <= '0;
        end else if (capture) begin
            mcand  <= {{SIZE{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= CW'(SIZE);
            neg    <= signed_mode & (a[SIZE-1] ^ b[SIZE-1]);
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (last_bit) begin
                c <= neg ? ('0 - acc_sum) : acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: SIZE=4 table and corner sequences,
// SIZE=4 exhaustive and SIZE=8 random operands against an arithmetic reference.
module tb_seq_multiplier;

    logic       clk;
    logic       rst;
    logic       start4, sm4;
    logic [3:0] a4, b4;
    logic       busy4, done4;
    logic [7:0] c4;
    logic       start8, sm8;
    logic [7:0] a8, b8;
    logic       busy8, done8;
    logic [15:0] c8;

    int n_checks = 0;
    int n_pass   = 0;

    seq_multiplier #(.SIZE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .c(c4)
    );

    seq_multiplier #(.SIZE(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .c(c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sm;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] ref4(input logic sm, input logic [3:0] x, input logic [3:0] y);
        int px = sm ? int'($signed(x)) : int'(x);
        int py = sm ? int'($signed(y)) : int'(y);
        return 8'(px * py);
    endfunction

    function automatic logic [15:0] ref8(input logic sm, input logic [7:0] x, input logic [7:0] y);
        int px = sm ? int'($signed(x)) : int'(x);
        int py = sm ? int'($signed(y)) : int'(y);
        return 16'(px * py);
    endfunction

    // Returns at the falling edge where done is seen; lat counts edges including the start edge.
    task automatic op4(input logic sm, input logic [3:0] ta, input logic [3:0] tb,
                       output logic [7:0] rc, output int lat, output int bcnt);
        @(negedge clk);
        sm4 = sm; a4 = ta; b4 = tb; start4 = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy4) bcnt++;
            if (done4) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("done4_seen", 32'(done4), 32'd1);
        rc = c4;
    endtask

    task automatic op8(input logic sm, input logic [7:0] ta, input logic [7:0] tb,
                       output logic [15:0] rc, output int lat);
        @(negedge clk);
        sm8 = sm; a8 = ta; b8 = tb; start8 = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        for (int i = 0; i < 40; i++) begin
            if (done8) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("done8_seen", 32'(done8), 32'd1);
        rc = c8;
    endtask

    initial begin
        logic [7:0]  rc;
        logic [15:0] rc8;
        logic [7:0]  prev;
        logic [7:0]  cd;
        int lat, bc, lat2, nd, first_lat;

        vt[0] = '{1'b0, 4'hF, 4'h9, 8'h87};
        vt[1] = '{1'b1, 4'hF, 4'h9, 8'h07};
        vt[2] = '{1'b1, 4'h8, 4'h8, 8'h40};
        vt[3] = '{1'b0, 4'h0, 4'hF, 8'h00};
        vt[4] = '{1'b0, 4'hF, 4'hF, 8'hE1};
        vt[5] = '{1'b1, 4'h7, 4'h8, 8'hC8};
        vt[6] = '{1'b1, 4'h8, 4'h7, 8'hC8};
        vt[7] = '{1'b1, 4'h0, 4'h8, 8'h00};
        vt[8] = '{1'b0, 4'h8, 4'h8, 8'h40};
        vt[9] = '{1'b1, 4'h3, 4'h5, 8'h0F};

        rst = 1'b1;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        #2;
        chk("reset_busy", 32'(busy4), 32'd0);
        chk("reset_done", 32'(done4), 32'd0);
        chk("reset_c4", 32'(c4), 32'd0);
        chk("reset_c8", 32'(c8), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            op4(vt[i].sm, vt[i].a, vt[i].b, rc, lat, bc);
            chk($sformatf("vec%0d_c", i), 32'(rc), 32'(vt[i].exp));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd5);
            chk($sformatf("vec%0d_busy", i), 32'(bc), 32'd4);
            @(negedge clk);
            chk($sformatf("vec%0d_done_once", i), 32'(done4), 32'd0);
            chk($sformatf("vec%0d_c_hold", i), 32'(c4), 32'(vt[i].exp));
        end

        // start pulsed mid-RUN with other operands must be ignored
        @(negedge clk);
        prev = c4;
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'hF; b4 = 4'h9;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start4 = 1'b0;
        nd = 0; first_lat = 0; cd = '0;
        for (int i = 0; i < 12; i++) begin
            if (done4) begin
                nd++;
                if (nd == 1) begin
                    first_lat = lat;
                    cd = c4;
                end
            end
            if (i == 1) begin
                start4 = 1'b1; a4 = 4'h3; b4 = 4'h3; sm4 = 1'b1;
            end
            if (i == 2) begin
                start4 = 1'b0;
                chk("midrun_c_hold", 32'(c4), 32'(prev));
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("midrun_done_count", 32'(nd), 32'd1);
        chk("midrun_lat", 32'(first_lat), 32'd5);
        chk("midrun_c", 32'(cd), 32'h87);

        // start held through DONE: back-to-back operations
        @(negedge clk);
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'hF; b4 = 4'h9;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        a4 = 4'h8; b4 = 4'h8; sm4 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done4) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("b2b_done1", 32'(done4), 32'd1);
        chk("b2b_lat1", 32'(lat), 32'd5);
        chk("b2b_c1", 32'(c4), 32'h87);
        @(posedge clk);
        lat2 = 1;
        @(negedge clk);
        start4 = 1'b0;
        chk("b2b_no_idle", 32'(busy4), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (done4) break;
            @(posedge clk);
            lat2++;
            @(negedge clk);
        end
        chk("b2b_done2", 32'(done4), 32'd1);
        chk("b2b_spacing", 32'(lat2), 32'd5);
        chk("b2b_c2", 32'(c4), 32'h40);

        // asynchronous reset two cycles into RUN
        @(negedge clk);
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'h7; b4 = 4'h7;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_c", 32'(c4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done4) nd++;
            @(negedge clk);
        end
        chk("rst_no_done", 32'(nd), 32'd0);

        // start ignored under reset, accepted on the first edge after release
        rst = 1'b1;
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'h5; b4 = 4'h3;
        @(posedge clk);
        #1;
        chk("rst_start_ignored", 32'(busy4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_edge_accept", 32'(busy4), 32'd1);
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (done4) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("post_rst_lat", 32'(lat), 32'd5);
        chk("post_rst_c", 32'(c4), 32'd15);

        // SIZE=4 exhaustive in both modes
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    op4(1'(s), 4'(x), 4'(y), rc, lat, bc);
                    chk($sformatf("ex4 s%0d %0d*%0d", s, x, y), 32'(rc), 32'(ref4(1'(s), 4'(x), 4'(y))));
                    chk($sformatf("ex4 lat s%0d %0d*%0d", s, x, y), 32'(lat), 32'd5);
                end
            end
        end

        // SIZE=8: corner operands then random operands
        op8(1'b1, 8'h80, 8'h80, rc8, lat);
        chk("s8_minmin", 32'(rc8), 32'h4000);
        op8(1'b0, 8'hFF, 8'hFF, rc8, lat);
        chk("u8_maxmax", 32'(rc8), 32'hFE01);
        op8(1'b1, 8'hFF, 8'h80, rc8, lat);
        chk("s8_m1_min", 32'(rc8), 32'h0080);
        op8(1'b1, 8'h7F, 8'h80, rc8, lat);
        chk("s8_max_min", 32'(rc8), 32'hC080);
        op8(1'b0, 8'h00, 8'hFF, rc8, lat);
        chk("u8_zero", 32'(rc8), 32'h0000);
        chk("u8_zero_lat", 32'(lat), 32'd9);
        for (int i = 0; i < 1500; i++) begin
            logic       s;
            logic [7:0] x, y;
            s = 1'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            op8(s, x, y, rc8, lat);
            chk($sformatf("rnd8 s%0d %0h*%0h", s, x, y), 32'(rc8), 32'(ref8(s, x, y)));
            chk($sformatf("rnd8 lat s%0d %0h*%0h", s, x, y), 32'(lat), 32'd9);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
